// File: rtl/nextasic_pkg.sv
// Shared definitions for the host-link packet path: op codes, payload
// lengths and the encoder state enum. The op values are the same ones the
// receive-side decoder matches against.
package nextasic_pkg;

    localparam int OP_W    = 16;
    localparam int SHIFT_W = 40;
    localparam int CNT_W   = 5;

    localparam logic [OP_W-1:0] OP_PWR_REPLY = 16'hc5ef;
    localparam logic [OP_W-1:0] OP_AUDIO_REQ = 16'h0700;
    localparam logic [OP_W-1:0] OP_KBD       = 16'hc600;
    localparam logic [OP_W-1:0] OP_MIC       = 16'hc700;

    localparam logic [CNT_W-1:0] LEN_PWR_REPLY = 5'd0;
    localparam logic [CNT_W-1:0] LEN_AUDIO_REQ = 5'd0;
    localparam logic [CNT_W-1:0] LEN_KBD       = 5'd24;
    localparam logic [CNT_W-1:0] LEN_MIC       = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OP,
        ST_DATA,
        ST_STOP
    } enc_state_t;

endpackage

// File: rtl/op_shifter.sv
// Serializer for the packet encoder: a 40-bit MSB-first shift register
// holding op + payload left-aligned, the bit currently on the line, and a
// per-field bit counter.
module op_shifter
    import nextasic_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               bit_tick,
    input  logic               load,
    input  logic [SHIFT_W-1:0] load_data,
    input  logic               shift_en,
    input  logic               cnt_clr,
    output logic               bit_out,
    output logic [CNT_W-1:0]   bit_cnt
);

    logic [SHIFT_W-1:0] sreg;

    // Load a fresh frame, or present the next MSB and advance on a bit tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg    <= '0;
            bit_out <= 1'b1;
            bit_cnt <= '0;
        end else if (load) begin
            sreg    <= load_data;
            bit_cnt <= '0;
        end else if (bit_tick && shift_en) begin
            bit_out <= sreg[SHIFT_W-1];
            sreg    <= {sreg[SHIFT_W-2:0], 1'b0};
            bit_cnt <= cnt_clr ? '0 : bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/op_encoder.sv
// Host-link packet encoder: arbitrates between power-reply, keyboard,
// audio-request and microphone sources and sends one framed packet at a
// time on the serial line. Define OP_ENCODER_MIC_EN to enable mic packets;
// without it the mic inputs are ignored and mic_ready stays low.
//
//   state | meaning
//   IDLE  | line high, waiting for a bit tick with a source pending
//   START | start bit (0) on the line
//   OP    | 16 op bits, MSB first
//   DATA  | payload bits, MSB first (skipped for zero-length payloads)
//   STOP  | stop bit (1); its ending tick may launch the next frame
module op_encoder
    import nextasic_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bit_tick,
    input  logic        pwr_reply_req,
    input  logic        audio_req,
    input  logic        kbd_valid,
    input  logic [23:0] kbd_data,
    output logic        kbd_ready,
    input  logic        mic_valid,
    input  logic [15:0] mic_data,
    output logic        mic_ready,
    output logic        so,
    output logic        busy
);

    enc_state_t         state, state_nxt;
    logic               pwr_pend, aud_pend;
    logic [CNT_W-1:0]   pay_len, load_len;
    logic [SHIFT_W-1:0] load_data;
    logic               mic_req, launch;
    logic               win_pwr, win_kbd, win_aud, win_mic;
    logic               shift_en, cnt_clr, bit_out;
    logic [CNT_W-1:0]   bit_cnt;

`ifdef OP_ENCODER_MIC_EN
    assign mic_req = mic_valid;
`else
    logic unused_mic;
    assign mic_req    = 1'b0;
    assign unused_mic = ^{mic_valid, mic_data};
`endif

    // Launches happen only on a tick that leaves IDLE or ends STOP.
    assign launch  = bit_tick && (state == ST_IDLE || state == ST_STOP)
                     && (pwr_pend || kbd_valid || aud_pend || mic_req);
    assign win_pwr = launch && pwr_pend;
    assign win_kbd = launch && !pwr_pend && kbd_valid;
    assign win_aud = launch && !pwr_pend && !kbd_valid && aud_pend;
    assign win_mic = launch && !pwr_pend && !kbd_valid && !aud_pend && mic_req;

    // Select the winner's op, left-aligned payload and payload length.
    always_comb begin
        load_data = {OP_AUDIO_REQ, 24'h0};
        load_len  = LEN_AUDIO_REQ;
        if (win_pwr) begin
            load_data = {OP_PWR_REPLY, 24'h0};
            load_len  = LEN_PWR_REPLY;
        end else if (win_kbd) begin
            load_data = {OP_KBD, kbd_data};
            load_len  = LEN_KBD;
`ifdef OP_ENCODER_MIC_EN
        end else if (win_mic) begin
            load_data = {OP_MIC, mic_data, 8'h00};
            load_len  = LEN_MIC;
`endif
        end
    end

    // Sticky request flags; a launch clears the winner, which also absorbs
    // a duplicate pulse landing on the launch cycle itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwr_pend <= 1'b0;
            aud_pend <= 1'b0;
            pay_len  <= '0;
        end else begin
            pwr_pend <= (pwr_pend | pwr_reply_req) & ~win_pwr;
            aud_pend <= (aud_pend | audio_req) & ~win_aud;
            if (launch)
                pay_len <= load_len;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and serializer control, advancing one bit per tick.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch)
                    state_nxt = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    shift_en  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = ST_OP;
                end
            end
            ST_OP: begin
                if (bit_tick) begin
                    if (bit_cnt == CNT_W'(OP_W - 1)) begin
                        if (pay_len != '0) begin
                            shift_en  = 1'b1;
                            cnt_clr   = 1'b1;
                            state_nxt = ST_DATA;
                        end else begin
                            state_nxt = ST_STOP;
                        end
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == pay_len - CNT_W'(1))
                        state_nxt = ST_STOP;
                    else
                        shift_en = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_tick)
                    state_nxt = launch ? ST_START : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Line level, busy flag and accept strobes.
    always_comb begin
        so        = 1'b1;
        busy      = (state != ST_IDLE);
        kbd_ready = win_kbd;
        mic_ready = win_mic;
        case (state)
            ST_START: so = 1'b0;
            ST_OP,
            ST_DATA:  so = bit_out;
            default:  so = 1'b1;
        endcase
    end

    op_shifter u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_tick  (bit_tick),
        .load      (launch),
        .load_data (load_data),
        .shift_en  (shift_en),
        .cnt_clr   (cnt_clr),
        .bit_out   (bit_out),
        .bit_cnt   (bit_cnt)
    );

endmodule

// File: tb/tb_op_encoder.sv
// Bench for op_encoder: stimulus pushes expected frames into a queue, a
// line monitor decodes frames from so on every bit tick and compares.
module tb_op_encoder;

    typedef struct {
        logic [15:0] op;
        logic [23:0] pay;
        int          len;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bit_tick = 1'b0;
    logic        pwr_reply_req = 1'b0;
    logic        audio_req = 1'b0;
    logic        kbd_valid = 1'b0;
    logic [23:0] kbd_data = '0;
    logic        kbd_ready;
    logic        mic_valid = 1'b0;
    logic [15:0] mic_data = '0;
    logic        mic_ready;
    logic        so;
    logic        busy;

    frame_t      exp_q[$];
    frame_t      cur_exp;
    int          n_tests = 0;
    int          n_fail = 0;
    int          tick_div = 0;
    bit          mon_active = 0;
    bit          last_was_stop = 0;
    int          mon_pos = 0;
    logic [15:0] got_op;
    logic [23:0] got_pay;
    int          frames_rx = 0;
    int          busy_ticks = 0;
    int          b2b_cnt = 0;
    int          kbd_rdy_cnt = 0;
    int          mic_rdy_cnt = 0;
    int          so_low_cnt = 0;
    int          frames_before;

    op_encoder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bit_tick      (bit_tick),
        .pwr_reply_req (pwr_reply_req),
        .audio_req     (audio_req),
        .kbd_valid     (kbd_valid),
        .kbd_data      (kbd_data),
        .kbd_ready     (kbd_ready),
        .mic_valid     (mic_valid),
        .mic_data      (mic_data),
        .mic_ready     (mic_ready),
        .so            (so),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // bit_tick: one cycle high in every four
    always @(negedge clk) begin
        tick_div = (tick_div == 3) ? 0 : tick_div + 1;
        bit_tick = (tick_div == 0);
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // strobe and line counters, sampled mid-cycle
    always @(negedge clk) begin
        #2;
        if (kbd_ready) kbd_rdy_cnt++;
        if (mic_ready) mic_rdy_cnt++;
        if (!so) so_low_cnt++;
    end

    // line monitor: one sample per bit period, just after the tick edge
    always @(posedge clk) begin
        if (bit_tick && reset_n) begin
            #1;
            if (reset_n) begin
                if (busy) busy_ticks++;
                if (!mon_active) begin
                    if (so == 1'b0) begin
                        mon_active = 1;
                        mon_pos = 0;
                        got_op = '0;
                        got_pay = '0;
                        if (last_was_stop) b2b_cnt++;
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_frame: got a start bit, expected none");
                            cur_exp = '{op: 16'h0, pay: 24'h0, len: 0};
                        end else begin
                            cur_exp = exp_q.pop_front();
                        end
                    end
                    last_was_stop = 0;
                end else begin
                    mon_pos++;
                    if (mon_pos <= 16)
                        got_op = {got_op[14:0], so};
                    else if (mon_pos <= 16 + cur_exp.len)
                        got_pay = {got_pay[22:0], so};
                    else begin
                        check("stop_bit", {39'h0, so}, 40'h1);
                        check("frame_op", {24'h0, got_op}, {24'h0, cur_exp.op});
                        check("frame_payload", {16'h0, got_pay}, {16'h0, cur_exp.pay});
                        frames_rx++;
                        mon_active = 0;
                        last_was_stop = 1;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || mon_active || busy) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({name, "_timeout"}, {39'h0, c >= 3000}, 40'h0);
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_tick();
        int c = 0;
        do begin
            @(posedge clk);
            c++;
        end while (!bit_tick && c < 20);
    endtask

    task automatic offer_kbd(input logic [23:0] d);
        int c = 0;
        kbd_data = d;
        kbd_valid = 1'b1;
        do begin
            @(negedge clk);
            #2;
            c++;
        end while (!kbd_ready && c < 2000);
        check("kbd_handshake_timeout", {39'h0, c >= 2000}, 40'h0);
        @(posedge clk);
        #1 kbd_valid = 1'b0;
    endtask

    task automatic offer_mic(input logic [15:0] d);
        int c = 0;
        mic_data = d;
        mic_valid = 1'b1;
        do begin
            @(negedge clk);
            #2;
            c++;
        end while (!mic_ready && c < 2000);
        check("mic_handshake_timeout", {39'h0, c >= 2000}, 40'h0);
        @(posedge clk);
        #1 mic_valid = 1'b0;
    endtask

    task automatic pulse_audio();
        @(negedge clk) audio_req = 1'b1;
        @(negedge clk) audio_req = 1'b0;
    endtask

    initial begin
        // reset values
        #1;
        check("rst_so", {39'h0, so}, 40'h1);
        check("rst_busy", {39'h0, busy}, 40'h0);
        check("rst_kbd_ready", {39'h0, kbd_ready}, 40'h0);
        check("rst_mic_ready", {39'h0, mic_ready}, 40'h0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // audio request alone
        frames_before = frames_rx;
        busy_ticks = 0;
        exp_q.push_back('{op: 16'h0700, pay: 24'h0, len: 0});
        pulse_audio();
        wait_idle("audio");
        check("audio_busy_ticks", busy_ticks, 18);
        check("audio_frames", frames_rx - frames_before, 1);

        // keyboard packet
        frames_before = frames_rx;
        kbd_rdy_cnt = 0;
        exp_q.push_back('{op: 16'hc600, pay: 24'h123456, len: 24});
        offer_kbd(24'h123456);
        wait_idle("kbd");
        check("kbd_ready_cycles", kbd_rdy_cnt, 1);
        check("kbd_frames", frames_rx - frames_before, 1);

        // simultaneous sources: priority and back-to-back frames
        frames_before = frames_rx;
        b2b_cnt = 0;
        kbd_rdy_cnt = 0;
        exp_q.push_back('{op: 16'hc5ef, pay: 24'h0, len: 0});
        exp_q.push_back('{op: 16'hc600, pay: 24'habcdef, len: 24});
        exp_q.push_back('{op: 16'h0700, pay: 24'h0, len: 0});
        @(negedge clk);
        pwr_reply_req = 1'b1;
        audio_req = 1'b1;
        kbd_data = 24'habcdef;
        kbd_valid = 1'b1;
        @(negedge clk);
        pwr_reply_req = 1'b0;
        audio_req = 1'b0;
        offer_kbd(24'habcdef);
        wait_idle("combo");
        check("combo_back_to_back", b2b_cnt, 2);
        check("combo_frames", frames_rx - frames_before, 3);
        check("combo_kbd_ready_cycles", kbd_rdy_cnt, 1);

        // coalescing: two pulses while pending, one more mid-frame
        frames_before = frames_rx;
        exp_q.push_back('{op: 16'h0700, pay: 24'h0, len: 0});
        wait_tick();
        pulse_audio();
        pulse_audio();
        begin
            int c = 0;
            while (!(mon_active && mon_pos >= 5) && c < 500) begin
                @(negedge clk);
                c++;
            end
            check("coalesce_midframe_timeout", {39'h0, c >= 500}, 40'h0);
        end
        exp_q.push_back('{op: 16'h0700, pay: 24'h0, len: 0});
        pulse_audio();
        wait_idle("coalesce");
        check("coalesce_frames", frames_rx - frames_before, 2);

        // reset in the middle of the op field
        exp_q.push_back('{op: 16'h0700, pay: 24'h0, len: 0});
        pulse_audio();
        begin
            int c = 0;
            while (!(mon_active && mon_pos == 8) && c < 500) begin
                @(negedge clk);
                c++;
            end
            check("reset_wait_timeout", {39'h0, c >= 500}, 40'h0);
        end
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midframe_reset_so", {39'h0, so}, 40'h1);
        check("midframe_reset_busy", {39'h0, busy}, 40'h0);
        exp_q.delete();
        mon_active = 0;
        last_was_stop = 0;
        frames_before = frames_rx;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        so_low_cnt = 0;
        repeat (150) @(negedge clk);
        check("post_reset_so_low", so_low_cnt, 0);
        check("post_reset_busy", {39'h0, busy}, 40'h0);
        check("post_reset_frames", frames_rx - frames_before, 0);

        // microphone sample
        frames_before = frames_rx;
        mic_rdy_cnt = 0;
`ifdef OP_ENCODER_MIC_EN
        exp_q.push_back('{op: 16'hc700, pay: 24'h00beef, len: 16});
        offer_mic(16'hbeef);
        wait_idle("mic");
        check("mic_ready_cycles", mic_rdy_cnt, 1);
        check("mic_frames", frames_rx - frames_before, 1);
`else
        so_low_cnt = 0;
        mic_data = 16'hbeef;
        mic_valid = 1'b1;
        repeat (200) @(negedge clk);
        mic_valid = 1'b0;
        check("mic_off_ready_cycles", mic_rdy_cnt, 0);
        check("mic_off_so_low", so_low_cnt, 0);
        check("mic_off_frames", frames_rx - frames_before, 0);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/op_encoder.md
OP_ENCODER -- requirements
Module: op_encoder

Interface
REQ-001 clk  input  1  single clock for all logic.
REQ-002 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-003 bit_tick  input  1  one-cycle strobe per serial bit period.
REQ-004 pwr_reply_req  input  1  one-cycle pulse: send power-on reply packet.
REQ-005 audio_req  input  1  one-cycle pulse: send audio-sample request packet.
REQ-006 kbd_valid  input  1  keyboard packet offered.
REQ-007 kbd_data  input  24  keyboard payload.
REQ-008 kbd_ready  output  1  one-cycle accept strobe for kbd_data.
REQ-009 mic_valid  input  1  microphone sample offered.
REQ-010 mic_data  input  16  microphone payload.
REQ-011 mic_ready  output  1  one-cycle accept strobe for mic_data.
REQ-012 so  output  1  serial out to host, idle high.
REQ-013 busy  output  1  high while a frame is on the line.

Function
REQ-014 Frame: start bit 0, 16-bit op MSB-first, payload MSB-first (0/16/24 bits), stop bit 1; every bit lasts exactly one bit_tick period.
REQ-015 Ops/payload: power reply 16'hc5ef/none; audio request 16'h0700/none; keyboard 16'hc600/24 bits; mic 16'hc700/16 bits.
REQ-016 States IDLE, START, OP, DATA, STOP; DATA is skipped when payload length is 0.
REQ-017 pwr_reply_req and audio_req set sticky pending flags; a pulse while its flag is already set is coalesced (one packet).
REQ-018 A pulse arriving during a frame of the same type sets the flag again and yields one further packet.
REQ-019 Launch: on a bit_tick in IDLE with any source pending, enter START and drive so=0 in the following cycle.
REQ-020 Priority at launch: power reply > keyboard > audio request > mic; losers stay pending.
REQ-021 Launch clears the winner's flag; for kbd/mic, the matching ready pulses high for exactly the launch cycle and the data is captured in that cycle.
REQ-022 kbd_valid/mic_valid hold with stable data until ready; a valid dropped before ready is permitted and sends nothing.
REQ-023 Each later bit_tick advances one bit; STOP lasts one period, then IDLE (so=1).
REQ-024 A pending source at the STOP-ending tick launches on that same tick, giving back-to-back frames with no idle bit.
REQ-025 busy = (state != IDLE); bit counter wraps to 0 at each field boundary.

Reset
REQ-026 While reset_n=0: so=1, busy=0, kbd_ready=0, mic_ready=0, state IDLE, all pending flags and shift data cleared.
REQ-027 Reset mid-frame aborts the frame immediately; the aborted packet is not resent after reset.

Configuration
REQ-028 Macro OP_ENCODER_MIC_EN: defined -> mic packets supported as above.
REQ-029 Not defined -> mic ports remain, mic_ready is constant 0, and no mic frame is ever sent.

Structure
REQ-030 Op constants, payload-length constants and the state enum SHALL live in shared package nextasic_pkg, alongside the decoder's op values.
REQ-031 Sub-module op_shifter (load, shift on bit_tick, 40-bit register, bit count) holds the serializer; op_encoder holds arbitration and the FSM.

Verification
REQ-032 audio_req pulse, bit_tick every 4 clk -> so pattern 0, 0000_0111_0000_0000, 1; busy high for 18 ticks.
REQ-033 kbd_valid with kbd_data=24'h123456 -> kbd_ready for 1 cycle at launch; 42-bit frame carries op c600 then 123456.
REQ-034 pwr_reply_req, audio_req and kbd_valid in the same cycle -> frames c5ef, c600+data, 0700 back-to-back with no idle bit between them.
REQ-035 Two audio_req pulses while idle-pending -> exactly one 0700 frame; a third pulse mid-frame -> exactly one more.
REQ-036 reset_n low at op bit 7 -> so=1 and busy=0 asynchronously; after release the line stays idle with no pending packet.
REQ-037 mic_valid with mic_data=16'hbeef: with the macro -> frame c700, beef; without it -> mic_ready stays 0 and so stays 1.
